// File: rtl/cg_memory_pkg.sv
`default_nettype none
// ============================================================================
// cg_memory_pkg: shared constants, helpers and types for the memory responder.
// Rev 1.0
// ============================================================================
package cg_memory_pkg;

    localparam int CG_DATA_WIDTH = 32;
    localparam int CG_DEPTH      = 1024;

    function automatic int cg_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    localparam int CG_OFFS        = cg_clog2(CG_DATA_WIDTH / 8);
    localparam int CG_INDEX_WIDTH = cg_clog2(CG_DEPTH);

    // One read in flight between the RAM read and the response queue.
    typedef struct packed {
        logic                     valid;
        logic [CG_DATA_WIDTH-1:0] data;
    } cg_ram_stage_t;

endpackage
`default_nettype wire

// File: rtl/cg_sync_fifo.sv
`default_nettype none
// ============================================================================
// cg_sync_fifo: synchronous FIFO with count, same-cycle push and pop allowed.
// Rev 1.0
// ============================================================================
module cg_sync_fifo
    import cg_memory_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_push,
    input  logic [WIDTH-1:0]                i_push_data,
    input  logic                            i_pop,
    output logic [WIDTH-1:0]                o_pop_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [cg_clog2(DEPTH+1)-1:0]    o_count
);

    localparam int PTR_W = cg_clog2(DEPTH);
    localparam int CNT_W = cg_clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = i_push && (count_q != FULL_CNT);
        do_pop   = i_pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Pointers wrap explicitly so DEPTH need not be a power of two.
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    assign o_pop_data = mem_q[rd_ptr_q];
    assign o_full     = (count_q == FULL_CNT);
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;

endmodule
`default_nettype wire

// File: rtl/cg_memory_responder.sv
`default_nettype none
// ============================================================================
// cg_memory_responder: memory-side handshake endpoint serving reads and writes
// from a synchronous RAM, with a credit-limited response queue. Rev 1.0
// ============================================================================
module cg_memory_responder
    import cg_memory_pkg::*;
#(
    parameter int    DATA_WIDTH = CG_DATA_WIDTH,
    parameter int    ADDR_WIDTH = 32,
    parameter int    DEPTH      = CG_DEPTH,
    parameter int    RESP_DEPTH = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  raddr_valid,
    output logic                  raddr_ready,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    localparam int OFFS  = cg_clog2(DATA_WIDTH / 8);
    localparam int IDX_W = cg_clog2(DEPTH);
    localparam int OUT_W = cg_clog2(RESP_DEPTH + 1);
    localparam logic [OUT_W-1:0] CREDITS = OUT_W'(RESP_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  live_q, live_d;
    cg_ram_stage_t         stage_q, stage_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;

    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic                  rd_accept;
    logic                  rd_pop;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OUT_W-1:0]      fifo_count;
    logic                  unused_bits;

    // Contents start uninitialised; INIT_FILE is carried only for port/parameter
    // compatibility with initiator-side instantiations.
    assign unused_bits = ^{raddr, waddr, fifo_full, fifo_count, (INIT_FILE == "")};

    always_comb begin
        rd_idx      = raddr[OFFS +: IDX_W];
        wr_idx      = waddr[OFFS +: IDX_W];
        raddr_ready = live_q && (outstanding_q < CREDITS);
        wdata_ready = live_q;
        rdata_valid = !fifo_empty;
        rdata       = fifo_empty ? '0 : fifo_head;
        rd_accept   = raddr_valid && raddr_ready;
        rd_pop      = rdata_valid && rdata_ready;
        wr_en       = wdata_valid && wdata_ready && wen;

        live_d        = 1'b1;
        stage_d.valid = rd_accept;
        stage_d.data  = mem_q[rd_idx];
        outstanding_d = outstanding_q + OUT_W'(rd_accept) - OUT_W'(rd_pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            live_q        <= 1'b0;
            stage_q       <= '0;
            outstanding_q <= '0;
        end else begin
            live_q        <= live_d;
            stage_q       <= stage_d;
            outstanding_q <= outstanding_d;
        end
    end

    // The stage samples the old word on a same-index write, giving read-first.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wdata;
        end
    end

    cg_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_push      (stage_q.valid),
        .i_push_data (stage_q.data),
        .i_pop       (rd_pop),
        .o_pop_data  (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_cg_memory_responder.sv
`default_nettype none
// ============================================================================
// tb_cg_memory_responder: directed stimulus with a response scoreboard queue.
// Rev 1.0
// ============================================================================
module tb_cg_memory_responder;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int RDEP  = 4;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          raddr_valid;
    logic          raddr_ready;
    logic [AW-1:0] raddr;
    logic          rdata_valid;
    logic          rdata_ready;
    logic [DW-1:0] rdata;
    logic          wdata_valid;
    logic          wdata_ready;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 i_clk = ~i_clk;

    cg_memory_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESP_DEPTH (RDEP),
        .INIT_FILE  ("")
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .raddr_valid (raddr_valid),
        .raddr_ready (raddr_ready),
        .raddr       (raddr),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: got no event within budget, expected one", name);
    endtask

    // Monitor: every response handshake pops and compares against the scoreboard.
    always @(negedge i_clk) begin
        if (rdata_valid === 1'b1 && rdata_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got %h, expected no response", rdata);
            end else begin
                check("resp_data", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic we);
        bit ok;
        int n;
        wdata_valid = 1'b1; waddr = a; wdata = d; wen = we;
        ok = 0; n = 0;
        while (!ok && n < 50) begin
            @(negedge i_clk);
            ok = (wdata_ready === 1'b1);
            n++;
        end
        if (!ok) timeout_fail("wdata_ready_wait");
        step();
        wdata_valid = 1'b0; wen = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] e);
        bit ok;
        int n;
        raddr_valid = 1'b1; raddr = a;
        ok = 0; n = 0;
        while (!ok && n < 50) begin
            @(negedge i_clk);
            ok = (raddr_ready === 1'b1);
            n++;
        end
        if (ok) exp_q.push_back(e);
        else timeout_fail("raddr_ready_wait");
        step();
        raddr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            timeout_fail("drain_wait");
            exp_q.delete();
        end
        step();
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge i_clk);
        check({tag, "_raddr_ready"}, 32'(raddr_ready), 32'd0);
        check({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
        check({tag, "_rdata"},       rdata,            32'd0);
        check({tag, "_wdata_ready"}, 32'(wdata_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc;
        logic [31:0] exp_v;
        i_rstn = 1'b0; raddr_valid = 1'b0; raddr = '0; rdata_ready = 1'b1;
        wdata_valid = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;

        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("rst");
        step();
        i_rstn = 1'b1;
        check_all_zero("rel");
        step();

        do_write(32'h0, 32'd1, 1'b1);
        do_write(32'h4, 32'd2, 1'b1);
        do_write(32'h8, 32'd3, 1'b1);
        do_write(32'hC, 32'd4, 1'b1);

        // Single write then read, with exact two-cycle latency.
        do_write(32'h10, 32'hDEADBEEF, 1'b1);
        do_read(32'h10, 32'hDEADBEEF);
        @(negedge i_clk);
        check("lat_cycle1_valid", 32'(rdata_valid), 32'd0);
        step();
        @(negedge i_clk);
        check("lat_cycle2_valid", 32'(rdata_valid), 32'd1);
        step();
        wait_drain();

        // Back-to-back reads at full throughput.
        for (int k = 0; k < 8; k++) begin
            raddr_valid = (k < 4);
            raddr       = 32'(k * 4);
            @(negedge i_clk);
            if (k < 4) begin
                check("b2b_raddr_ready", 32'(raddr_ready), 32'd1);
                if (raddr_ready === 1'b1) exp_q.push_back(32'(k + 1));
            end
            if (k >= 2 && k <= 5) check("b2b_rdata_valid", 32'(rdata_valid), 32'd1);
            step();
        end
        raddr_valid = 1'b0;
        wait_drain();

        // Backpressure: credits limit acceptance to RESP_DEPTH reads.
        rdata_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            raddr_valid = 1'b1;
            raddr       = (acc < 4) ? 32'(acc * 4) : 32'h10;
            exp_v       = (acc < 4) ? 32'(acc + 1) : 32'hDEADBEEF;
            @(negedge i_clk);
            if (raddr_ready === 1'b1) begin
                exp_q.push_back(exp_v);
                acc++;
            end
            step();
        end
        check("bp_accepted", 32'(acc), 32'd4);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("bp_raddr_ready", 32'(raddr_ready), 32'd0);
            check("bp_rdata_stable", rdata, 32'd1);
            step();
        end
        raddr_valid = 1'b0;
        rdata_ready = 1'b1;
        wait_drain();
        @(negedge i_clk);
        check("bp_raddr_reassert", 32'(raddr_ready), 32'd1);
        step();

        // Same-cycle read and write to one index returns the old word.
        do_write(32'h20, 32'h1111, 1'b1);
        raddr_valid = 1'b1; raddr = 32'h20;
        wdata_valid = 1'b1; waddr = 32'h20; wdata = 32'h2222; wen = 1'b1;
        @(negedge i_clk);
        check("coll_raddr_ready", 32'(raddr_ready), 32'd1);
        check("coll_wdata_ready", 32'(wdata_ready), 32'd1);
        if (raddr_ready === 1'b1) exp_q.push_back(32'h1111);
        step();
        raddr_valid = 1'b0; wdata_valid = 1'b0; wen = 1'b0;
        do_read(32'h20, 32'h2222);
        wait_drain();

        // wen=0 consumes without writing; addresses alias modulo DEPTH words.
        do_write(32'h40, 32'hABCD, 1'b1);
        wdata_valid = 1'b1; waddr = 32'h40; wdata = 32'h5555; wen = 1'b0;
        @(negedge i_clk);
        check("wen0_wdata_ready", 32'(wdata_ready), 32'd1);
        step();
        wdata_valid = 1'b0;
        do_read(32'h40, 32'hABCD);
        do_write(32'h40 + DEPTH * 4, 32'h7777, 1'b1);
        do_read(32'h40, 32'h7777);
        do_read(32'h43, 32'h7777);
        wait_drain();

        // Reset with queued responses discards them; RAM is retained.
        rdata_ready = 1'b0;
        do_read(32'h0, 32'd1);
        do_read(32'h4, 32'd2);
        repeat (3) step();
        @(negedge i_clk);
        check("pre_rst_rdata_valid", 32'(rdata_valid), 32'd1);
        step();
        i_rstn = 1'b0;
        step();
        exp_q.delete();
        rdata_ready = 1'b1;
        check_all_zero("mid_rst");
        step();
        i_rstn = 1'b1;
        check_all_zero("mid_rel");
        step();
        do_read(32'h20, 32'h2222);
        wait_drain();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
